frame_read_arbiter: RTL

Shares the single read port of the double-buffered framebuffer BRAM between the VGA scan-out reader and the Ethernet frame exporter. It replaces the plain address mux that is keyed on the exporter's transmit-enable. Each cycle it grants at most one requester, pipelines the chosen address to the BRAM, and tags each read so the returned pixel goes back only to its owner. It sits between `vga_display`, `ether_export` and `bram_manager`.

---
 rtl/frame_read_arbiter_pkg.sv | 25 ++
 rtl/frame_read_arbiter_if.sv | 35 +++
 rtl/read_tag_pipe.sv | 30 +++
 rtl/frame_read_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/frame_read_arbiter_pkg.sv
// Shared types for the framebuffer path: colour vector, widths, read owner tags and
// the arbiter state encoding.
package frame_read_arbiter_pkg;

    localparam int unsigned ADDR_BITS = 17;
    localparam int unsigned CHAN_BITS = 4;

    typedef struct packed {
        logic [CHAN_BITS-1:0] r;
        logic [CHAN_BITS-1:0] g;
        logic [CHAN_BITS-1:0] b;
    } vec3_t;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerVga  = 2'd1,
        OwnerEth  = 2'd2
    } owner_t;

    typedef enum logic [0:0] {
        StShared = 1'b0,
        StLocked = 1'b1
    } arb_state_t;

endpackage

// File: rtl/frame_read_arbiter_if.sv
// Read-port bundle between the two framebuffer readers, the arbiter and bram_manager.
interface frame_read_arbiter_if
    import frame_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LEN = ADDR_BITS,
    parameter int unsigned DATA_W   = 4
);
    logic                vga_req_in;
    logic [ADDR_LEN-1:0] vga_addr_in;
    logic                vga_gnt_out;
    logic [DATA_W-1:0]   vga_data_out;
    logic                vga_valid_out;
    logic                eth_req_in;
    logic [ADDR_LEN-1:0] eth_addr_in;
    logic                eth_gnt_out;
    logic [DATA_W-1:0]   eth_data_out;
    logic                eth_valid_out;
    logic                eth_lock_in;
    logic [ADDR_LEN-1:0] bram_addr_out;
    logic [DATA_W-1:0]   bram_data_in;
    logic                locked_out;

    modport master (
        output vga_req_in, vga_addr_in, eth_req_in, eth_addr_in, eth_lock_in, bram_data_in,
        input  vga_gnt_out, vga_data_out, vga_valid_out, eth_gnt_out, eth_data_out,
               eth_valid_out, bram_addr_out, locked_out
    );

    modport slave (
        input  vga_req_in, vga_addr_in, eth_req_in, eth_addr_in, eth_lock_in, bram_data_in,
        output vga_gnt_out, vga_data_out, vga_valid_out, eth_gnt_out, eth_data_out,
               eth_valid_out, bram_addr_out, locked_out
    );

endinterface

// File: rtl/read_tag_pipe.sv
// Shift register carrying the owner of each issued BRAM read until its data returns.
module read_tag_pipe
    import frame_read_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t tag_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                tag_q[i] <= OwnerNone;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < Depth; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_o = tag_q[Depth-1];

endmodule

// File: rtl/frame_read_arbiter.sv
// Arbitrates the framebuffer read port between VGA scan-out and the Ethernet exporter,
// routing each returned pixel back to the requester that issued the read.
module frame_read_arbiter
    import frame_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LEN     = ADDR_BITS,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input logic                 clk_in,
    input logic                 rst_in,
    frame_read_arbiter_if.slave bus_io
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic [CntW-1:0]     starve_q, starve_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]   vga_data_q, eth_data_q;
    logic                vga_valid_q, eth_valid_q;
    logic                vga_gnt, eth_gnt, locked, starved;
    owner_t              tag_in, tag_out;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StShared;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StShared: if (bus_io.eth_lock_in)  state_d = StLocked;
            StLocked: if (!bus_io.eth_lock_in) state_d = StShared;
            default:  state_d = StShared;
        endcase
    end

    // Ethernet only overrides VGA once it has been denied STARVE_LIMIT cycles in a row.
    assign starved = (STARVE_LIMIT != 0) && (starve_q == CntMax);

    always_comb begin
        vga_gnt = 1'b0;
        eth_gnt = 1'b0;
        locked  = 1'b0;
        unique case (state_q)
            StShared: begin
                if (bus_io.vga_req_in && !(starved && bus_io.eth_req_in)) begin
                    vga_gnt = 1'b1;
                end else if (bus_io.eth_req_in) begin
                    eth_gnt = 1'b1;
                end
            end
            StLocked: begin
                locked  = 1'b1;
                eth_gnt = bus_io.eth_req_in;
            end
            default: ;
        endcase
        if (!rst_in) begin
            vga_gnt = 1'b0;
            eth_gnt = 1'b0;
        end
    end

    always_comb begin
        starve_d = '0;
        if (state_q == StShared && bus_io.eth_req_in && !eth_gnt) begin
            starve_d = (starve_q == CntMax) ? starve_q : starve_q + 1'b1;
        end
    end

    always_comb begin
        tag_in = OwnerNone;
        addr_d = addr_q;
        if (vga_gnt) begin
            tag_in = OwnerVga;
            addr_d = bus_io.vga_addr_in;
        end else if (eth_gnt) begin
            tag_in = OwnerEth;
            addr_d = bus_io.eth_addr_in;
        end
    end

    // One extra stage covers the address register in front of the BRAM.
    read_tag_pipe #(
        .Depth (READ_LATENCY + 1)
    ) u_tag_pipe (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            starve_q    <= '0;
            addr_q      <= '0;
            vga_data_q  <= '0;
            eth_data_q  <= '0;
            vga_valid_q <= 1'b0;
            eth_valid_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            vga_valid_q <= (tag_out == OwnerVga);
            eth_valid_q <= (tag_out == OwnerEth);
            if (tag_out == OwnerVga) vga_data_q <= bus_io.bram_data_in;
            if (tag_out == OwnerEth) eth_data_q <= bus_io.bram_data_in;
        end
    end

    assign bus_io.vga_gnt_out   = vga_gnt;
    assign bus_io.eth_gnt_out   = eth_gnt;
    assign bus_io.locked_out    = locked;
    assign bus_io.bram_addr_out = addr_q;
    assign bus_io.vga_data_out  = vga_data_q;
    assign bus_io.vga_valid_out = vga_valid_q;
    assign bus_io.eth_data_out  = eth_data_q;
    assign bus_io.eth_valid_out = eth_valid_q;

endmodule
